regfile_burst_reader: RTL and testbench
=======================================

Name: regfile_burst_reader

Overview:
- Read-side initiator for the N-bit M-wide register file.
- On a start command it issues a burst of sequential reads, beginning at a start address, for a given word count.
- Read data is captured into a small FIFO and presented downstream on a valid/ready stream, with a last-word flag and a done pulse.
- Used to dump register contents to display/UART paths without the consumer knowing the register file timing.

Parameters:
- P_RegWidth, 3, register address width; the file holds 2**P_RegWidth words.
- P_BitWidth, 32, data width of each register and of the stream.
- P_CountWidth, 4, width of the burst length field (P_RegWidth+1 by default).

Ports:
- In_Clock_50MHz  input  1  single system clock, all logic rising-edge.
- In_Reset_n  input  1  asynchronous active-low reset.
- In_Start  input  1  one-cycle burst request; sampled only in IDLE.
- In_StartAddress  input  P_RegWidth  first register address.
- In_Count  input  P_CountWidth  number of words to read.
- Out_Address  output  P_RegWidth  register file address.
- Out_Read  output  1  register file read strobe.
- In_ReadData  input  P_BitWidth  register file read data.
- Out_Data  output  P_BitWidth  stream data (FIFO head).
- Out_Valid  output  1  stream data valid.
- In_Ready  input  1  downstream accepts when high with Out_Valid.
- Out_Last  output  1  high with Out_Valid on the final word of the burst.
- Out_Busy  output  1  high from accepted start until the done pulse.
- Out_Done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, immediate):
  - All outputs go to 0.
  - FIFO is emptied, counters are cleared, FSM enters IDLE.
  - A burst in progress is discarded; no Out_Done is generated for it.
- Register file read latency is fixed at 1:
  - In_ReadData is valid in the cycle after Out_Read is high.
  - It is written into the FIFO on that cycle's closing edge.
- FIFO:
  - Depth 4, show-ahead: Out_Data = head, Out_Valid = not empty.
  - Pop on Out_Valid & In_Ready.
  - A push and a pop in the same cycle are both honoured.
- Read issue rule: Out_Read = 1 in a cycle only if all of the following hold:
  - state is READ;
  - words remaining to issue > 0;
  - FIFO occupancy + reads in flight (0 or 1) < 4.
  - This guarantees the FIFO never overflows under any In_Ready pattern.
- Addressing:
  - Out_Address = In_StartAddress for the first read, then +1 per issued read.
  - Addresses wrap modulo 2**P_RegWidth.
  - Out_Address is held unchanged when Out_Read is low.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE with In_Start = 1 and In_Count != 0: latch address and count, then go to READ. Out_Busy = 1 from the next cycle.
  - IDLE with In_Start = 1 and In_Count == 0: go to DONE; no reads, no stream data.
  - READ: issue per the rule above; when the last read is issued, go to DRAIN.
  - DRAIN: wait until the last word has been popped (handshake on the Out_Last word), then go to DONE.
  - DONE: Out_Done = 1 for exactly one cycle, Out_Busy = 0 in that cycle, then go to IDLE.
  - In_Start outside IDLE is ignored; there is no queuing.
- Out_Last is asserted only while the head entry is the final word; it is tagged in the FIFO alongside the data.
- Throughput with In_Ready held high is 1 word/cycle after startup:
  - start sampled at cycle 0;
  - first Out_Read in cycle 1;
  - first Out_Valid in cycle 3.
- Out_Valid must not drop while In_Ready is low and the FIFO is non-empty. Out_Data is stable while Out_Valid & !In_Ready.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/READ/DRAIN/DONE);
  - constant READ_LATENCY = 1;
  - constant FIFO_DEPTH = 4.
- One natural sub-module, nbit_sync_fifo: parameterised width and depth, show-ahead, with push/pop/full/empty/occupancy outputs. Instantiate it with width P_BitWidth+1, the extra bit carrying the last flag.

Test Plan:
- Register file model preloaded with R[i] = 0x100+i. Start addr 2, count 4, In_Ready = 1 → Out_Data stream 0x102, 0x103, 0x104, 0x105 on consecutive cycles 3-6; Out_Last on 0x105; Out_Done at cycle 7.
- Start addr 6, count 4 → addresses 6, 7, 0, 1; data 0x106, 0x107, 0x100, 0x101.
- Count 0 → no Out_Read, no Out_Valid; Out_Done pulses 1 cycle after start.
- Count 8, In_Ready low for 10 cycles then high → at most 4 Out_Read pulses before the first pop; all 8 words arrive in order with no loss or duplication; Out_Data is stable while stalled.
- In_Ready toggling 1,0,1,0 during a count-5 burst → 5 handshakes, exactly one Out_Last, one Out_Done; a second In_Start mid-burst is ignored.
- Assert In_Reset_n = 0 mid-burst → all outputs 0 immediately; a fresh start afterwards streams correctly from its own start address.

Source files
------------

// File: rtl/regfile_burst_reader_pkg.sv
// Shared definitions for the register-file burst reader.
//   state_e       : burst FSM state encoding
//   READ_LATENCY  : cycles from Out_Read to valid In_ReadData
//   FIFO_DEPTH    : entries in the output stream FIFO
package regfile_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int READ_LATENCY = 1;
  localparam int FIFO_DEPTH   = 4;

endpackage

// File: rtl/nbit_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data (dropped when full and not popping)
//   pop               : read request (ignored when empty)
//   pop_data          : current head entry, valid while !empty
//   full, empty       : status flags
//   occupancy         : number of stored entries
// A push and a pop in the same cycle are both honoured, including when full.
module nbit_sync_fifo #(
  parameter int P_Width = 33,
  parameter int P_Depth = 4,
  localparam int PTR_W  = (P_Depth > 1) ? $clog2(P_Depth) : 1,
  localparam int OCC_W  = $clog2(P_Depth + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_Width-1:0] push_data,
  input  logic               pop,
  output logic [P_Width-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [OCC_W-1:0]   occupancy
);

  logic [P_Width-1:0] mem_q [P_Depth];
  logic [P_Width-1:0] mem_d [P_Depth];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(P_Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_W'(P_Depth));
  assign occupancy = occ_q;
  assign pop_data  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_Depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/regfile_burst_reader.sv
// Burst read initiator for a register file with a valid/ready output stream.
// Ports:
//   In_Clock_50MHz, In_Reset_n       : clock, asynchronous active-low reset
//   In_Start, In_StartAddress, In_Count : burst request (sampled only in IDLE)
//   Out_Address, Out_Read, In_ReadData  : register file read port (latency 1)
//   Out_Data, Out_Valid, In_Ready, Out_Last : output stream
//   Out_Busy, Out_Done               : burst status
// Stream handshake: a word transfers in any cycle where Out_Valid and In_Ready
// are both high. Once Out_Valid is high it stays high, with Out_Data and
// Out_Last unchanged, until that transfer happens.
module regfile_burst_reader
  import regfile_burst_reader_pkg::*;
#(
  parameter int P_RegWidth   = 3,
  parameter int P_BitWidth   = 32,
  parameter int P_CountWidth = 4
) (
  input  logic                    In_Clock_50MHz,
  input  logic                    In_Reset_n,
  input  logic                    In_Start,
  input  logic [P_RegWidth-1:0]   In_StartAddress,
  input  logic [P_CountWidth-1:0] In_Count,
  output logic [P_RegWidth-1:0]   Out_Address,
  output logic                    Out_Read,
  input  logic [P_BitWidth-1:0]   In_ReadData,
  output logic [P_BitWidth-1:0]   Out_Data,
  output logic                    Out_Valid,
  input  logic                    In_Ready,
  output logic                    Out_Last,
  output logic                    Out_Busy,
  output logic                    Out_Done
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_e                  state_q, state_d;
  logic [P_RegWidth-1:0]   addr_q, addr_d;
  logic [P_CountWidth-1:0] remain_q, remain_d;
  // Per-stage valid and last-word tags for reads travelling through the
  // register file pipeline.
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    rd_issue;
  int                      in_flight;
  logic                    fifo_push;
  logic [P_BitWidth:0]     fifo_wdata;
  logic [P_BitWidth:0]     fifo_rdata;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OCC_W-1:0]        fifo_occ;
  logic                    head_last;

  assign fifo_push  = vld_pipe_q[READ_LATENCY-1];
  assign fifo_wdata = {last_pipe_q[READ_LATENCY-1], In_ReadData};
  assign head_last  = fifo_rdata[P_BitWidth];
  assign fifo_pop   = !fifo_empty && In_Ready;

  nbit_sync_fifo #(
    .P_Width (P_BitWidth + 1),
    .P_Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (In_Clock_50MHz),
    .rst_n     (In_Reset_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  always_comb begin
    in_flight = $countones(vld_pipe_q);
    // Reserve a FIFO slot for every read still in the pipeline so the FIFO
    // can never overflow, whatever the downstream does with In_Ready.
    rd_issue  = (state_q == ST_READ) && (remain_q != '0) && !fifo_full &&
                ((int'(fifo_occ) + in_flight) < FIFO_DEPTH);

    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;

    case (state_q)
      ST_IDLE: begin
        if (In_Start) begin
          if (In_Count != '0) begin
            addr_d   = In_StartAddress;
            remain_d = In_Count;
            state_d  = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == P_CountWidth'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && head_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
    vld_pipe_d[0]  = rd_issue;
    last_pipe_d[0] = rd_issue && (remain_q == P_CountWidth'(1));

    busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
    if (!In_Reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Out_Address = addr_q;
  assign Out_Read    = rd_issue;
  assign Out_Valid   = !fifo_empty;
  // Mask the head when empty so stale storage never shows on the stream.
  assign Out_Data    = fifo_empty ? '0 : fifo_rdata[P_BitWidth-1:0];
  assign Out_Last    = !fifo_empty && head_last;
  assign Out_Busy    = busy_q;
  assign Out_Done    = done_q;

endmodule

// File: tb/tb_regfile_burst_reader.sv
module tb_regfile_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  start_addr;
  logic [3:0]  count;
  logic [2:0]  rf_addr;
  logic        rf_read;
  logic [31:0] rf_rdata;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_burst_reader dut (
    .In_Clock_50MHz  (clk),
    .In_Reset_n      (rst_n),
    .In_Start        (start),
    .In_StartAddress (start_addr),
    .In_Count        (count),
    .Out_Address     (rf_addr),
    .Out_Read        (rf_read),
    .In_ReadData     (rf_rdata),
    .Out_Data        (s_data),
    .Out_Valid       (s_valid),
    .In_Ready        (s_ready),
    .Out_Last        (s_last),
    .Out_Busy        (busy),
    .Out_Done        (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: R[i] = 0x100 + i, one-cycle read latency.
  // Returns junk when not read so a mistimed capture shows up.
  always @(posedge clk) begin
    if (rf_read) rf_rdata <= 32'h100 + {29'd0, rf_addr};
    else         rf_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " addr"},  {29'd0, rf_addr}, 32'd0);
    check({tag, " read"},  {31'd0, rf_read}, 32'd0);
    check({tag, " data"},  s_data,           32'd0);
    check({tag, " valid"}, {31'd0, s_valid}, 32'd0);
    check({tag, " last"},  {31'd0, s_last},  32'd0);
    check({tag, " busy"},  {31'd0, busy},    32'd0);
    check({tag, " done"},  {31'd0, done},    32'd0);
  endtask

  // ---------------- vector table ----------------
  // mode 0: ready always high; 1: ready toggles 1,0,1,0 and a second start
  // is driven mid-burst; 2: ready low for cycles 0..9 then high.
  typedef struct {
    logic [2:0] addr;
    logic [3:0] cnt;
    int         mode;
    int         exp_done;   // expected done cycle, -1 when not pinned
  } vec_t;

  vec_t vecs[7];

  // Drive one burst starting in cycle 0 and score the stream against the
  // expected queue built from the register file contents.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp_q[$];
    logic [2:0]  exp_addr_q[$];
    logic [2:0]  a;
    logic [31:0] exp_d;
    logic [31:0] held_data;
    logic        held_last;
    logic        stalled;
    int          done_cyc;
    int          first_rd;
    int          first_vld;
    int          n_last;
    int          n_done;
    int          reads_pre_pop;
    int          popped;
    int          c;

    for (int i = 0; i < int'(v.cnt); i++) begin
      a = v.addr + 3'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(32'h100 + {29'd0, a});
    end
    done_cyc = -1; first_rd = -1; first_vld = -1;
    n_last = 0; n_done = 0; reads_pre_pop = 0; popped = 0;
    stalled = 1'b0; held_data = '0; held_last = 1'b0;

    @(posedge clk);
    #1;
    c = 0;
    while (c < 80 && done_cyc < 0) begin
      // drive inputs for cycle c
      start      = (c == 0) || (v.mode == 1 && c == 4);
      start_addr = (c == 0) ? v.addr : 3'd0;
      count      = (c == 0) ? v.cnt  : 4'd3;
      case (v.mode)
        1:       s_ready = (c % 2 == 0);
        2:       s_ready = (c >= 10);
        default: s_ready = 1'b1;
      endcase

      @(negedge clk);
      if (stalled) begin
        check({tag, " stall valid"}, {31'd0, s_valid}, 32'd1);
        check({tag, " stall data"},  s_data,  held_data);
        check({tag, " stall last"},  {31'd0, s_last}, {31'd0, held_last});
      end
      if (rf_read) begin
        if (first_rd < 0) first_rd = c;
        if (popped == 0) reads_pre_pop++;
        if (exp_addr_q.size() == 0) begin
          check({tag, " extra read"}, {29'd0, rf_addr}, 32'hFFFF_FFFF);
        end else begin
          a = exp_addr_q.pop_front();
          check({tag, " rd addr"}, {29'd0, rf_addr}, {29'd0, a});
        end
      end
      if (s_valid && first_vld < 0) first_vld = c;
      if (s_valid && s_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check({tag, " extra word"}, s_data, 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check({tag, " data"}, s_data, exp_d);
          check({tag, " last"}, {31'd0, s_last}, {31'd0, exp_q.size() == 0});
        end
        if (s_last) n_last++;
      end
      stalled   = s_valid && !s_ready;
      held_data = s_data;
      held_last = s_last;
      if (done) begin
        n_done++;
        done_cyc = c;
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
      end else if (c >= 1 && v.cnt != 0) begin
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;

    if (done_cyc < 0) begin
      check({tag, " done timeout"}, 32'd0, 32'd1);
    end
    check({tag, " words left"}, exp_q.size(), 32'd0);
    check({tag, " last count"}, n_last, (v.cnt != 0) ? 32'd1 : 32'd0);
    check({tag, " words popped"}, popped, {28'd0, v.cnt});
    if (v.exp_done >= 0) check({tag, " done cycle"}, done_cyc, v.exp_done);
    if (v.cnt != 0) begin
      check({tag, " first read cycle"},  first_rd,  32'd1);
      check({tag, " first valid cycle"}, first_vld, 32'd3);
    end else begin
      check({tag, " no reads"}, first_rd,  32'hFFFF_FFFF);
      check({tag, " no valid"}, first_vld, 32'hFFFF_FFFF);
    end
    if (v.mode == 2) begin
      check({tag, " reads before pop <= 4"}, {31'd0, reads_pre_pop <= 4}, 32'd1);
    end

    // Idle afterwards: no stray reads, data or done pulses.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, " idle read"},  {31'd0, rf_read}, 32'd0);
      check({tag, " idle valid"}, {31'd0, s_valid}, 32'd0);
      check({tag, " idle done"},  {31'd0, done},    32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;

    vecs[0] = '{addr: 3'd2, cnt: 4'd4, mode: 0, exp_done: 7};
    vecs[1] = '{addr: 3'd6, cnt: 4'd4, mode: 0, exp_done: 7};
    vecs[2] = '{addr: 3'd0, cnt: 4'd0, mode: 0, exp_done: 1};
    vecs[3] = '{addr: 3'd0, cnt: 4'd8, mode: 2, exp_done: -1};
    vecs[4] = '{addr: 3'd3, cnt: 4'd5, mode: 1, exp_done: -1};
    vecs[5] = '{addr: 3'd7, cnt: 4'd8, mode: 0, exp_done: 11};
    vecs[6] = '{addr: 3'd5, cnt: 4'd1, mode: 0, exp_done: 4};

    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    count = '0;
    s_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-burst: outputs clear immediately, then a new burst is clean.
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 3'd1; count = 4'd8; s_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset valid", {31'd0, s_valid}, 32'd1);
    check("pre-reset busy",  {31'd0, busy},    32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rv = '{addr: 3'd5, cnt: 4'd3, mode: 0, exp_done: 6};
    run_vec(rv, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
